// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared constants for the memory arbiter: the FSM state encoding, the
// default CPU starvation limit and the default word-address width.
// No ports; imported by mem_arbiter and mem_arb_burst_ctr.
package mem_arb_pkg;

    // Arbiter FSM encoding (plain constants so older tools and dumps stay readable)
    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_CPU        = 2'd1;
    localparam logic [1:0] ST_VID        = 2'd2;
    localparam logic [1:0] ST_VID_RESUME = 2'd3;

    // Video words completed while a CPU request waits before the CPU is forced in
    localparam int STARVE_LIMIT_DEF = 4;

    // Word-address width (byte address bits 31:2)
    localparam int AW_DEF = 30;

endpackage

// File: rtl/mem_arb_burst_ctr.sv
// mem_arb_burst_ctr
// Holds the current video burst word address and the number of words still
// to be fetched.  A load captures a new burst (length 0 means 256 words); a
// step advances to the next word.  The address wraps modulo 2^AW.
// Ports:
//   I_clk, I_rst_n : clock, asynchronous active-low reset
//   I_load         : capture I_addr / I_len as a new burst
//   I_addr, I_len  : burst start word address and length
//   I_step         : one word of the burst has completed
//   O_addr         : word address of the next word to fetch
//   O_last         : the word currently being fetched is the final one
module mem_arb_burst_ctr
    import mem_arb_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic          I_clk,
    input  logic          I_rst_n,
    input  logic          I_load,
    input  logic [AW-1:0] I_addr,
    input  logic [7:0]    I_len,
    input  logic          I_step,
    output logic [AW-1:0] O_addr,
    output logic          O_last
);

    logic [AW-1:0] addr_q, addr_d;
    logic [8:0]    rem_q,  rem_d;

    // NOTE: every signal assigned here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        if (I_load) begin
            addr_d = I_addr;
            rem_d  = (I_len == 8'd0) ? 9'd256 : {1'b0, I_len};
        end else if (I_step) begin
            addr_d = addr_q + AW'(1);
            rem_d  = rem_q - 9'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments only, so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            addr_q <= '0;
            rem_q  <= '0;
        end else begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
        end
    end

    assign O_addr = addr_q;
    assign O_last = (rem_q == 9'd1);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Arbitrates a single-word memory port between a CPU (single read/write
// accesses) and a video engine (read bursts).  Video normally wins, but a CPU
// request that has waited through STARVE_LIMIT video words suspends the burst;
// the burst resumes after the CPU word at the address it left off.
// One memory word is outstanding at a time and O_mem_req drops for at least
// one cycle between words.
// Ports:
//   I_clk, I_rst_n                  : clock, asynchronous active-low reset
//   I_cpu_*, O_cpu_ack, O_cpu_data_r: CPU request / completion
//   I_vid_*, O_vid_valid/_data/_done: video burst request / returned words
//   O_mem_*, I_mem_done/_data_r     : memory word port
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int AW           = AW_DEF
) (
    input  logic          I_clk,
    input  logic          I_rst_n,
    input  logic          I_cpu_req,
    input  logic [AW-1:0] I_cpu_address,
    input  logic [3:0]    I_cpu_byte_we,
    input  logic [31:0]   I_cpu_data_w,
    output logic          O_cpu_ack,
    output logic [31:0]   O_cpu_data_r,
    input  logic          I_vid_req,
    input  logic [AW-1:0] I_vid_address,
    input  logic [7:0]    I_vid_len,
    output logic          O_vid_valid,
    output logic [31:0]   O_vid_data,
    output logic          O_vid_done,
    output logic          O_mem_req,
    output logic [AW-1:0] O_mem_address,
    output logic [3:0]    O_mem_byte_we,
    output logic [31:0]   O_mem_data_w,
    input  logic          I_mem_done,
    input  logic [31:0]   I_mem_data_r
);

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [1:0]    state_q,     state_d;
    logic          susp_q,      susp_d;
    logic [SW-1:0] starve_q,    starve_d;
    logic          rst_done_q,  rst_done_d;
    logic          cpu_ack_q,   cpu_ack_d;
    logic [31:0]   cpu_data_q,  cpu_data_d;
    logic          vid_valid_q, vid_valid_d;
    logic [31:0]   vid_data_q,  vid_data_d;
    logic          vid_done_q,  vid_done_d;
    logic          mem_req_q,   mem_req_d;
    logic [AW-1:0] mem_addr_q,  mem_addr_d;
    logic [3:0]    mem_we_q,    mem_we_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;

    logic          vid_load, vid_step, vid_last;
    logic [AW-1:0] vid_addr;
    logic [SW-1:0] starve_inc;

    mem_arb_burst_ctr #(.AW(AW)) u_burst_ctr (
        .I_clk   (I_clk),
        .I_rst_n (I_rst_n),
        .I_load  (vid_load),
        .I_addr  (I_vid_address),
        .I_len   (I_vid_len),
        .I_step  (vid_step),
        .O_addr  (vid_addr),
        .O_last  (vid_last)
    );

    // Starvation count including the video word completing this cycle
    assign starve_inc = (starve_q == STARVE_MAX) ? starve_q : starve_q + SW'(1);

    always_comb begin
        state_d     = state_q;
        susp_d      = susp_q;
        starve_d    = starve_q;
        rst_done_d  = 1'b1;
        cpu_ack_d   = 1'b0;
        cpu_data_d  = cpu_data_q;
        vid_valid_d = 1'b0;
        vid_data_d  = vid_data_q;
        vid_done_d  = 1'b0;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = mem_we_q;
        mem_wdata_d = mem_wdata_q;
        vid_load    = 1'b0;
        vid_step    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // rst_done_q holds off the first grant to the second edge after reset
                if (rst_done_q) begin
                    if (I_cpu_req && (!I_vid_req || starve_q == STARVE_MAX)) begin
                        state_d     = ST_CPU;
                        mem_req_d   = 1'b1;
                        mem_addr_d  = I_cpu_address;
                        mem_we_d    = I_cpu_byte_we;
                        mem_wdata_d = I_cpu_data_w;
                    end else if (I_vid_req) begin
                        state_d  = ST_VID;
                        vid_load = 1'b1;
                    end
                end
            end
            ST_CPU: begin
                if (!mem_req_q) begin
                    // Entered from a suspended burst: issue after the one-cycle gap
                    mem_req_d   = 1'b1;
                    mem_addr_d  = I_cpu_address;
                    mem_we_d    = I_cpu_byte_we;
                    mem_wdata_d = I_cpu_data_w;
                end else if (I_mem_done) begin
                    mem_req_d  = 1'b0;
                    cpu_ack_d  = 1'b1;
                    cpu_data_d = I_mem_data_r;
                    starve_d   = '0;
                    state_d    = susp_q ? ST_VID_RESUME : ST_IDLE;
                end
            end
            ST_VID: begin
                if (!mem_req_q) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = vid_addr;
                    mem_we_d   = 4'd0;
                end else if (I_mem_done) begin
                    mem_req_d   = 1'b0;
                    vid_valid_d = 1'b1;
                    vid_data_d  = I_mem_data_r;
                    vid_step    = 1'b1;
                    if (I_cpu_req) begin
                        starve_d = starve_inc;
                    end
                    if (vid_last) begin
                        vid_done_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else if (I_cpu_req && starve_inc == STARVE_MAX) begin
                        susp_d  = 1'b1;
                        state_d = ST_CPU;
                    end
                end
            end
            default: begin  // ST_VID_RESUME
                susp_d  = 1'b0;
                state_d = ST_VID;
            end
        endcase
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q     <= ST_IDLE;
            susp_q      <= 1'b0;
            starve_q    <= '0;
            rst_done_q  <= 1'b0;
            cpu_ack_q   <= 1'b0;
            cpu_data_q  <= '0;
            vid_valid_q <= 1'b0;
            vid_data_q  <= '0;
            vid_done_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            susp_q      <= susp_d;
            starve_q    <= starve_d;
            rst_done_q  <= rst_done_d;
            cpu_ack_q   <= cpu_ack_d;
            cpu_data_q  <= cpu_data_d;
            vid_valid_q <= vid_valid_d;
            vid_data_q  <= vid_data_d;
            vid_done_q  <= vid_done_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign O_cpu_ack     = cpu_ack_q;
    assign O_cpu_data_r  = cpu_data_q;
    assign O_vid_valid   = vid_valid_q;
    assign O_vid_data    = vid_data_q;
    assign O_vid_done    = vid_done_q;
    assign O_mem_req     = mem_req_q;
    assign O_mem_address = mem_addr_q;
    assign O_mem_byte_we = mem_we_q;
    assign O_mem_data_w  = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter.  A behavioural memory with programmable
// latency serves the memory port from a backing store; expected memory
// accesses, video words and CPU completions are queued when stimulus is
// driven and compared as the DUT produces them.
module tb_mem_arbiter;

    typedef struct {
        logic [29:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
    } mem_txn_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } vid_txn_t;

    typedef struct {
        logic [31:0] data;
        logic        is_read;
    } cpu_txn_t;

    logic        clk;
    logic        rst_n;
    logic        cpu_req;
    logic [29:0] cpu_address;
    logic [3:0]  cpu_byte_we;
    logic [31:0] cpu_data_w;
    logic        cpu_ack;
    logic [31:0] cpu_data_r;
    logic        vid_req;
    logic [29:0] vid_address;
    logic [7:0]  vid_len;
    logic        vid_valid;
    logic [31:0] vid_data;
    logic        vid_done;
    logic        mem_req;
    logic [29:0] mem_address;
    logic [3:0]  mem_byte_we;
    logic [31:0] mem_data_w;
    logic        mem_done;
    logic [31:0] mem_data_r;

    mem_txn_t mem_exp[$];
    vid_txn_t vid_exp[$];
    cpu_txn_t cpu_exp[$];
    logic [31:0] mem_store [logic [29:0]];

    int n_checks = 0;
    int n_fail   = 0;
    int mem_lat  = 3;
    int mem_served = 0;
    int vid_cnt  = 0;
    int ack_cnt  = 0;

    mem_arbiter dut (
        .I_clk         (clk),
        .I_rst_n       (rst_n),
        .I_cpu_req     (cpu_req),
        .I_cpu_address (cpu_address),
        .I_cpu_byte_we (cpu_byte_we),
        .I_cpu_data_w  (cpu_data_w),
        .O_cpu_ack     (cpu_ack),
        .O_cpu_data_r  (cpu_data_r),
        .I_vid_req     (vid_req),
        .I_vid_address (vid_address),
        .I_vid_len     (vid_len),
        .O_vid_valid   (vid_valid),
        .O_vid_data    (vid_data),
        .O_vid_done    (vid_done),
        .O_mem_req     (mem_req),
        .O_mem_address (mem_address),
        .O_mem_byte_we (mem_byte_we),
        .O_mem_data_w  (mem_data_w),
        .I_mem_done    (mem_done),
        .I_mem_data_r  (mem_data_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_word(input logic [29:0] a);
        if (mem_store.exists(a)) return mem_store[a];
        return {a, 2'b11} ^ 32'h5A5A_C3C3;
    endfunction

    // Main thread drives and observes just after the falling edge
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_burst(input logic [29:0] a, input logic [7:0] len);
        int n;
        logic [29:0] wa;
        n = (len == 8'd0) ? 256 : int'(len);
        for (int i = 0; i < n; i++) begin
            wa = a + 30'(i);
            mem_exp.push_back('{addr: wa, we: 4'd0, wdata: 32'd0});
            vid_exp.push_back('{data: rd_word(wa), last: (i == n - 1)});
        end
    endtask

    task automatic run_burst(input logic [29:0] a, input logic [7:0] len,
                             input int budget, output int pulses);
        int  v0;
        bit  seen;
        push_burst(a, len);
        v0 = vid_cnt;
        vid_req = 1'b1;
        vid_address = a;
        vid_len = len;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            if (vid_done) seen = 1'b1;
        end
        vid_req = 1'b0;
        check("burst_done_seen", 64'(seen), 64'd1);
        pulses = vid_cnt - v0;
    endtask

    // Behavioural memory: completes each word mem_lat falling edges after it is seen
    initial begin
        int wait_cnt;
        mem_txn_t t;
        logic [31:0] w;
        mem_done = 1'b0;
        mem_data_r = '0;
        wait_cnt = 0;
        forever begin
            @(negedge clk);
            if (mem_done) begin
                mem_done = 1'b0;
                if (rst_n) check("mem_req_gap", 64'(mem_req), 64'd0);
            end else if (mem_req && rst_n) begin
                wait_cnt++;
                if (wait_cnt >= mem_lat) begin
                    wait_cnt = 0;
                    check("mem_access_expected", 64'(mem_exp.size() != 0), 64'd1);
                    if (mem_exp.size() != 0) begin
                        t = mem_exp.pop_front();
                        check("mem_addr", 64'(mem_address), 64'(t.addr));
                        check("mem_we", 64'(mem_byte_we), 64'(t.we));
                        if (t.we != 4'd0) check("mem_wdata", 64'(mem_data_w), 64'(t.wdata));
                    end
                    if (mem_byte_we == 4'd0) begin
                        mem_data_r = rd_word(mem_address);
                    end else begin
                        w = rd_word(mem_address);
                        for (int b = 0; b < 4; b++)
                            if (mem_byte_we[b]) w[8*b +: 8] = mem_data_w[8*b +: 8];
                        mem_store[mem_address] = w;
                        mem_data_r = 32'hFFFF_FFFF;
                    end
                    mem_done = 1'b1;
                    mem_served++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Output monitor: pops the scoreboard on every video word and CPU completion
    initial begin
        vid_txn_t v;
        cpu_txn_t c;
        forever begin
            @(negedge clk);
            if (rst_n && vid_valid) begin
                vid_cnt++;
                check("vid_word_expected", 64'(vid_exp.size() != 0), 64'd1);
                if (vid_exp.size() != 0) begin
                    v = vid_exp.pop_front();
                    check("vid_data", 64'(vid_data), 64'(v.data));
                    check("vid_done_with_last", 64'(vid_done), 64'(v.last));
                end
            end
            if (rst_n && cpu_ack) begin
                ack_cnt++;
                check("cpu_ack_expected", 64'(cpu_exp.size() != 0), 64'd1);
                if (cpu_exp.size() != 0) begin
                    c = cpu_exp.pop_front();
                    if (c.is_read) check("cpu_data_r", 64'(cpu_data_r), 64'(c.data));
                end
            end
        end
    end

    initial begin
        int  cyc, pulses, v0, a0;
        bit  seen, done;

        rst_n = 1'b0;
        cpu_req = 1'b0; cpu_address = '0; cpu_byte_we = '0; cpu_data_w = '0;
        vid_req = 1'b0; vid_address = '0; vid_len = '0;
        repeat (3) step();

        // Reset state
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_cpu_ack", 64'(cpu_ack), 64'd0);
        check("rst_vid_valid", 64'(vid_valid), 64'd0);
        check("rst_vid_done", 64'(vid_done), 64'd0);
        check("rst_mem_address", 64'(mem_address), 64'd0);
        rst_n = 1'b1;
        repeat (2) step();

        // 1: CPU read at 0x100, memory answers after 3 cycles
        mem_lat = 3;
        mem_store[30'h100] = 32'hDEAD_BEEF;
        mem_exp.push_back('{addr: 30'h100, we: 4'd0, wdata: 32'd0});
        cpu_exp.push_back('{data: 32'hDEAD_BEEF, is_read: 1'b1});
        v0 = vid_cnt;
        cpu_req = 1'b1; cpu_address = 30'h100; cpu_byte_we = 4'd0; cpu_data_w = 32'h0;
        cyc = 0; seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            step();
            cyc++;
            if (cpu_ack) seen = 1'b1;
        end
        cpu_req = 1'b0;
        check("cpu_rd_ack_seen", 64'(seen), 64'd1);
        check("cpu_rd_latency", 64'(cyc), 64'd4);
        repeat (3) step();
        check("cpu_rd_data_held", 64'(cpu_data_r), 64'hDEAD_BEEF);
        check("cpu_rd_no_video", 64'(vid_cnt - v0), 64'd0);

        // 2: video burst at 0x200, length 4
        mem_lat = 2;
        run_burst(30'h200, 8'd4, 100, pulses);
        check("burst4_pulses", 64'(pulses), 64'd4);
        repeat (2) step();

        // 3: length-16 burst, CPU write raised during word 1 is forced in after 4 words
        mem_lat = 2;
        for (int i = 0; i < 4; i++)
            mem_exp.push_back('{addr: 30'h1000 + 30'(i), we: 4'd0, wdata: 32'd0});
        mem_exp.push_back('{addr: 30'h50, we: 4'hF, wdata: 32'hCAFE_F00D});
        for (int i = 4; i < 16; i++)
            mem_exp.push_back('{addr: 30'h1000 + 30'(i), we: 4'd0, wdata: 32'd0});
        for (int i = 0; i < 16; i++)
            vid_exp.push_back('{data: rd_word(30'h1000 + 30'(i)), last: (i == 15)});
        cpu_exp.push_back('{data: 32'd0, is_read: 1'b0});
        v0 = vid_cnt; a0 = ack_cnt;
        vid_req = 1'b1; vid_address = 30'h1000; vid_len = 8'd16;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            step();
            if (mem_req) seen = 1'b1;
        end
        check("s3_first_word_issued", 64'(seen), 64'd1);
        cpu_req = 1'b1; cpu_address = 30'h50; cpu_byte_we = 4'hF; cpu_data_w = 32'hCAFE_F00D;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            step();
            if (cpu_ack) cpu_req = 1'b0;
            if (vid_done) done = 1'b1;
        end
        vid_req = 1'b0;
        cpu_req = 1'b0;
        check("s3_burst_done_seen", 64'(done), 64'd1);
        check("s3_pulses", 64'(vid_cnt - v0), 64'd16);
        check("s3_cpu_acks", 64'(ack_cnt - a0), 64'd1);
        repeat (2) step();

        // 4: address wrap at the top of the word space
        mem_lat = 1;
        run_burst(30'h3FFF_FFFE, 8'd3, 100, pulses);
        check("wrap_pulses", 64'(pulses), 64'd3);
        repeat (2) step();

        // 5: length 0 means 256 words
        mem_lat = 1;
        run_burst(30'h800, 8'd0, 2000, pulses);
        check("len0_pulses", 64'(pulses), 64'd256);
        repeat (2) step();

        // 6: reset during word 2 of a burst, then a fresh CPU read
        mem_lat = 3;
        push_burst(30'h400, 8'd4);
        a0 = mem_served;
        vid_req = 1'b1; vid_address = 30'h400; vid_len = 8'd4;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            step();
            if (mem_served - a0 == 1 && mem_req && !mem_done) seen = 1'b1;
        end
        check("s6_word2_outstanding", 64'(seen), 64'd1);
        rst_n = 1'b0;
        #1;
        check("s6_mem_req_async", 64'(mem_req), 64'd0);
        check("s6_mem_address", 64'(mem_address), 64'd0);
        check("s6_vid_data", 64'(vid_data), 64'd0);
        check("s6_cpu_data_r", 64'(cpu_data_r), 64'd0);
        vid_req = 1'b0;
        mem_exp.delete();
        vid_exp.delete();
        repeat (3) step();
        mem_exp.push_back('{addr: 30'h104, we: 4'd0, wdata: 32'd0});
        cpu_exp.push_back('{data: rd_word(30'h104), is_read: 1'b1});
        rst_n = 1'b1;
        cpu_req = 1'b1; cpu_address = 30'h104; cpu_byte_we = 4'd0; cpu_data_w = 32'h0;
        step();
        check("s6_no_grant_first_edge", 64'(mem_req), 64'd0);
        step();
        check("s6_grant_second_edge", 64'(mem_req), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            step();
            if (cpu_ack) seen = 1'b1;
        end
        cpu_req = 1'b0;
        check("s6_cpu_ack_seen", 64'(seen), 64'd1);
        check("s6_cpu_data", 64'(cpu_data_r), 64'(rd_word(30'h104)));

        repeat (5) step();
        check("mem_exp_drained", 64'(mem_exp.size()), 64'd0);
        check("vid_exp_drained", 64'(vid_exp.size()), 64'd0);
        check("cpu_exp_drained", 64'(cpu_exp.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be:
- STARVE_LIMIT, 4: video words completed while a CPU request waits before the CPU is forced in.
- AW, 30: word-address width (byte address bits 31:2).
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- I_clk, in, 1: single clock for all logic.
- I_rst_n, in, 1: reset, asynchronous, active-low.
- I_cpu_req, in, 1: CPU single-word access request, held until O_cpu_ack.
- I_cpu_address, in, AW: CPU word address.
- I_cpu_byte_we, in, 4: byte write enables; 0 means read.
- I_cpu_data_w, in, 32: CPU write data.
- O_cpu_ack, out, 1: one-cycle completion pulse.
- O_cpu_data_r, out, 32: CPU read data, valid with O_cpu_ack and held until the next CPU completion.
- I_vid_req, in, 1: video burst-read request, held until O_vid_done.
- I_vid_address, in, AW: burst start word address.
- I_vid_len, in, 8: burst length in words; 0 means 256.
- O_vid_valid, out, 1: one-cycle pulse per returned video word.
- O_vid_data, out, 32: video read word, valid with O_vid_valid.
- O_vid_done, out, 1: one-cycle pulse coincident with the last O_vid_valid.
- O_mem_req, out, 1: memory request, held until I_mem_done.
- O_mem_address, out, AW: memory word address.
- O_mem_byte_we, out, 4: memory byte enables; 0 means read.
- O_mem_data_w, out, 32: memory write data.
- I_mem_done, in, 1: one-cycle completion of the outstanding word.
- I_mem_data_r, in, 32: read data, valid with I_mem_done.

Function
REQ-003 The state machine SHALL have states IDLE, CPU, VID, and VID_RESUME; at most one memory word SHALL be outstanding.
REQ-004 In IDLE with only I_cpu_req high, the next state SHALL be CPU; with only I_vid_req high, VID; with both high, VID unless starve_cnt equals STARVE_LIMIT, in which case CPU.
REQ-005 On entering VID from IDLE, the block SHALL latch I_vid_address into vid_addr and I_vid_len into vid_rem, with 0 loaded as 256 (9-bit counter).
REQ-006 In CPU, O_mem_req SHALL be 1 and O_mem_address, O_mem_byte_we, and O_mem_data_w SHALL be driven from the CPU inputs, registered at grant and stable until I_mem_done.
REQ-007 On I_mem_done in CPU, O_cpu_ack SHALL pulse in the following cycle with O_cpu_data_r equal to I_mem_data_r (read data is don't-care for writes), starve_cnt SHALL clear, and the next state SHALL be VID_RESUME if a burst is suspended, else IDLE.
REQ-008 In VID, O_mem_req SHALL be 1 with O_mem_address equal to vid_addr and O_mem_byte_we equal to 0.
REQ-009 On each I_mem_done in VID:
- O_vid_valid SHALL pulse in the following cycle with O_vid_data equal to I_mem_data_r.
- vid_addr SHALL increment modulo 2^AW, wrapping from all-ones to 0.
- vid_rem SHALL decrement by one.
REQ-010 When vid_rem reaches 0, O_vid_done SHALL pulse together with the final O_vid_valid and the next state SHALL be IDLE.
REQ-011 After any non-final video word, if I_cpu_req is high and starve_cnt (including that word) equals STARVE_LIMIT, the block SHALL mark the burst suspended and go to CPU; otherwise it SHALL stay in VID.
REQ-012 VID_RESUME SHALL clear the suspended flag and enter VID in one cycle, preserving vid_addr and vid_rem.
REQ-013 starve_cnt SHALL increment on each completed video word while I_cpu_req is high and the CPU is not granted, saturating at STARVE_LIMIT.
REQ-014 O_mem_req SHALL deassert for at least one cycle between consecutive words.
REQ-015 Handling of boundary and protocol events:
- I_mem_done with no outstanding request SHALL be ignored.
- Inputs SHALL be sampled only at grant.
- Requester deassertion before completion is a protocol violation with undefined outcome.

Reset
REQ-016 Asserting I_rst_n low SHALL, asynchronously and at any time including mid-transaction, force:
- state to IDLE;
- all outputs to 0;
- starve_cnt, vid_addr, and vid_rem to 0, and the suspended flag clear.
REQ-017 After reset release, the first grant SHALL occur no earlier than the second rising edge of I_clk.

Structure
REQ-018 The state encoding and the default STARVE_LIMIT SHALL reside in the shared package mem_arb_pkg.
REQ-019 The block SHALL contain one sub-module, mem_arb_burst_ctr, holding vid_addr and vid_rem with load, step, and last outputs; all other logic SHALL be flat.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- CPU read at 0x100, memory returns 0xDEADBEEF after 3 cycles -> O_cpu_ack one cycle later with O_cpu_data_r = 0xDEADBEEF; no video activity.
- Video burst at 0x200, len 4 -> four O_vid_valid pulses at addresses 0x200-0x203, O_vid_done with the fourth pulse.
- Burst len 16 with CPU write (byte_we 0xF) raised during word 1 -> CPU granted after 4 video words, then the burst resumes at word 5 with no address gap.
- Burst at 0x3FFFFFFE, len 3 -> addresses 0x3FFFFFFE, 0x3FFFFFFF, 0x0.
- Burst with len 0 -> exactly 256 O_vid_valid pulses.
- Reset asserted mid-burst during word 2 -> O_mem_req = 0 immediately; after release, a new CPU request is served normally.
